// File: rtl/mem_pkg.sv
// Encodings and helpers shared by the memory access stage.
// The alignment helper is only called when MEM_ALIGN_CHECK_EN is defined.
package mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis_s;
        case (size)
            SZ_WORD: mis_s = (addr_lo != 2'd0);
            SZ_HALF: mis_s = addr_lo[0];
            SZ_BYTE: mis_s = 1'b0;
            default: mis_s = 1'b1;
        endcase
        return mis_s;
    endfunction

endpackage

// File: rtl/mem_access_unit_extract.sv
// Load lane selection with sign/zero extension (module mem_lane_extract).
// Combinational: the MDR register lives in the top level.
module mem_lane_extract
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Pick the addressed lane and extend it to a full word
    always_comb begin
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        case (size)
            SZ_HALF: result = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            SZ_BYTE: result = is_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: one load/store at a time into a fixed-latency word RAM.
// Define MEM_ALIGN_CHECK_EN to reject misaligned requests with resp_err.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t            state_r, state_nxt_s;
    logic [2:0]        cnt_r;
    logic              write_r, unsigned_r;
    logic [1:0]        size_r, addr_lo_r;
    logic              accept_s, misalign_s;
    logic [31:0]       ext_s;
    logic              req_ready_d, resp_valid_d, resp_err_d, ram_en_d, ram_we_d;
    logic [31:0]       resp_rdata_d, ram_wdata_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [3:0]        ram_be_d;
    logic              unused_s;

    assign accept_s = req_valid && req_ready;
    assign unused_s = ^req_addr[31:ADDR_W+2];

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_s = is_misaligned(req_size, req_addr[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    mem_lane_extract u_extract (
        .rdata       (ram_rdata),
        .addr_lo     (addr_lo_r),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .result      (ext_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = misalign_s ? ST_RESP : ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (write_r) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = (READ_LAT == 1) ? ST_CAPTURE : ST_WAIT;
                end
            end
            ST_WAIT:    state_nxt_s = (cnt_r <= 3'd1) ? ST_CAPTURE : ST_WAIT;
            ST_CAPTURE: state_nxt_s = ST_RESP;
            ST_RESP:    state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Request fields and the read-latency countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            write_r    <= 1'b0;
            unsigned_r <= 1'b0;
            size_r     <= 2'd0;
            addr_lo_r  <= 2'd0;
            cnt_r      <= 3'd0;
        end else begin
            if (accept_s) begin
                write_r    <= req_write;
                unsigned_r <= req_unsigned;
                size_r     <= req_size;
                addr_lo_r  <= req_addr[1:0];
            end
            case (state_r)
                ST_ISSUE: cnt_r <= 3'(READ_LAT - 1);
                ST_WAIT:  cnt_r <= cnt_r - 3'd1;
                default:  cnt_r <= cnt_r;
            endcase
        end
    end

    // Output decode against the upcoming state; RAM fields come straight from the request
    always_comb begin
        req_ready_d  = (state_nxt_s == ST_IDLE);
        resp_valid_d = (state_nxt_s == ST_RESP);
        resp_err_d   = accept_s && misalign_s;
        resp_rdata_d = (state_r == ST_CAPTURE) ? ext_s : resp_rdata;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr;
        ram_be_d     = ram_be;
        ram_wdata_d  = ram_wdata;
        if (state_nxt_s == ST_ISSUE) begin
            ram_en_d   = 1'b1;
            ram_we_d   = req_write;
            ram_addr_d = req_addr[ADDR_W+1:2];
            if (req_write) begin
                case (req_size)
                    SZ_HALF: begin
                        ram_be_d    = req_addr[1] ? BE_HALF_HI : BE_HALF_LO;
                        ram_wdata_d = {2{req_wdata[15:0]}};
                    end
                    SZ_BYTE: begin
                        ram_be_d    = BE_BYTE0 << req_addr[1:0];
                        ram_wdata_d = {4{req_wdata[7:0]}};
                    end
                    default: begin
                        ram_be_d    = BE_WORD;
                        ram_wdata_d = req_wdata;
                    end
                endcase
            end else begin
                ram_be_d    = BE_WORD;
                ram_wdata_d = req_wdata;
            end
        end else begin
            ram_en_d = 1'b0;
            ram_we_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            resp_err   <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_be     <= 4'b0000;
            ram_wdata  <= 32'h0000_0000;
        end else begin
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            ram_en     <= ram_en_d;
            ram_we     <= ram_we_d;
            ram_addr   <= ram_addr_d;
            ram_be     <= ram_be_d;
            ram_wdata  <= ram_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural RAM and byte-array model.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the misalignment response.
module tb_mem_access_unit;

    localparam int ADDR_W   = 8;
    localparam int READ_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              resp_valid, resp_err;
    logic [31:0]       resp_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata, ram_rdata;

    int          checks = 0;
    int          failures = 0;
    logic        ram_init;
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] mdr_exp;
    logic [31:0] ram [0:255];
    logic [31:0] rd_pipe [0:READ_LAT-1];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] init_word(int w);
        return (32'(w) * 32'h0101_0101) ^ 32'h5A3C_96E1;
    endfunction

    // Synchronous RAM; read data is garbage except exactly READ_LAT cycles after a read
    assign ram_rdata = rd_pipe[READ_LAT-1];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int w = 0; w < 256; w++) ram[w] <= init_word(w);
        end else if (ram_en && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        rd_pipe[0] <= (ram_en && !ram_we) ? ram[ram_addr] : $urandom;
        for (int s = 1; s < READ_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd2) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(int eff, int n, logic uns);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[eff+i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd_obs, output logic [3:0] be_obs,
                          output logic [31:0] wd_obs, output logic err_obs);
        int n, eff, k, en_cnt, en_at, resp_at, ready_bad, exp_resp;
        logic mis, we_obs;
        logic [ADDR_W-1:0] addr_obs;
        logic [3:0] be_e;
        logic [31:0] wd_e, ld_e;
        n   = nbytes(sz);
        eff = (int'(addr[9:0]) / n) * n;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (sz == 2'd3) || (int'(addr[1:0]) % n != 0);
`else
        mis = 1'b0;
`endif
        be_e = wr ? 4'(((32'd1 << n) - 32'd1) << (eff % 4)) : 4'b1111;
        for (int i = 0; i < 4; i++) wd_e[8*i +: 8] = wd[8*(i % n) +: 8];
        ld_e = model_load(eff, n, uns);
        exp_resp = mis ? 1 : (wr ? 2 : 2 + READ_LAT);
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_wait got=%b exp=1", req_ready); end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        en_cnt = 0; en_at = -1; resp_at = -1; ready_bad = 0;
        rd_obs = 32'hx; be_obs = 4'hx; wd_obs = 32'hx; err_obs = 1'bx; we_obs = 1'bx; addr_obs = 'x;
        for (k = 1; k <= 24 && resp_at < 0; k++) begin
            if (req_ready !== 1'b0) ready_bad++;
            if (ram_en === 1'b1) begin
                en_cnt++; en_at = k; we_obs = ram_we; addr_obs = ram_addr; be_obs = ram_be; wd_obs = ram_wdata;
            end
            if (resp_valid === 1'b1) begin resp_at = k; err_obs = resp_err; rd_obs = resp_rdata; end
            @(negedge clk);
        end
        checks++;
        if (resp_at != exp_resp) begin failures++; $display("FAIL resp_latency addr=%h got=%0d exp=%0d", addr, resp_at, exp_resp); end
        checks++;
        if (en_cnt != (mis ? 0 : 1)) begin failures++; $display("FAIL ram_en_count got=%0d exp=%0d", en_cnt, mis ? 0 : 1); end
        if (!mis) begin
            checks++;
            if (en_at != 1 || we_obs !== wr || addr_obs !== addr[ADDR_W+1:2] || be_obs !== be_e) begin
                failures++;
                $display("FAIL ram_issue got at=%0d we=%b addr=%h be=%b exp at=1 we=%b addr=%h be=%b",
                         en_at, we_obs, addr_obs, be_obs, wr, addr[ADDR_W+1:2], be_e);
            end
            if (wr) begin
                checks++;
                if (wd_obs !== wd_e) begin failures++; $display("FAIL ram_wdata got=%h exp=%h", wd_obs, wd_e); end
            end
        end
        checks++;
        if (err_obs !== mis) begin failures++; $display("FAIL resp_err got=%b exp=%b", err_obs, mis); end
        if (!mis && !wr) mdr_exp = ld_e;
        checks++;
        if (rd_obs !== mdr_exp) begin failures++; $display("FAIL resp_rdata addr=%h sz=%0d got=%h exp=%h", addr, sz, rd_obs, mdr_exp); end
        checks++;
        if (ready_bad != 0) begin failures++; $display("FAIL ready_busy got=%0d high cycles exp=0", ready_bad); end
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL after_resp got valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready);
        end
        if (!mis && wr) for (int i = 0; i < n; i++) ref_mem[eff+i] = wd[8*i +: 8];
    endtask

    task automatic test_reset();
        rst = 1'b1; ram_init = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, ram_en, ram_we, ram_be, ram_addr, resp_rdata, ram_wdata}
            !== {1'b1, 4'b0000, 4'b0000, {ADDR_W{1'b0}}, 64'd0}) begin
            failures++;
            $display("FAIL reset_values got rdy=%b v=%b e=%b en=%b we=%b be=%b a=%h rd=%h wd=%h exp rdy=1 rest 0",
                     req_ready, resp_valid, resp_err, ram_en, ram_we, ram_be, ram_addr, resp_rdata, ram_wdata);
        end
        rst = 1'b0; ram_init = 1'b0;
        mdr_exp = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd, wdo; logic [3:0] be; logic err;
        do_req(1'b1, 2'd0, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, be, wdo, err);
        checks++;
        if (be !== 4'b1111) begin failures++; $display("FAIL word_store_be got=%b exp=1111", be); end
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, rd, be, wdo, err);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word_load got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_byte_loads();
        logic [31:0] rd, wdo; logic [3:0] be; logic err;
        do_req(1'b1, 2'd0, 1'b0, 32'h20, 32'h80FF_7F01, rd, be, wdo, err);
        do_req(1'b0, 2'd2, 1'b0, 32'h23, 32'h0, rd, be, wdo, err);
        checks++;
        if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL byte23_signed got=%h exp=ffffff80", rd); end
        do_req(1'b0, 2'd2, 1'b1, 32'h22, 32'h0, rd, be, wdo, err);
        checks++;
        if (rd !== 32'h0000_00FF) begin failures++; $display("FAIL byte22_unsigned got=%h exp=000000ff", rd); end
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, be, wdo, err);
        checks++;
        if (rd !== 32'h0000_0001) begin failures++; $display("FAIL byte20_signed got=%h exp=00000001", rd); end
    endtask

    task automatic test_store_lanes();
        logic [31:0] rd, wdo; logic [3:0] be; logic err;
        do_req(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_ABCD, rd, be, wdo, err);
        checks++;
        if (be !== 4'b1100 || wdo !== 32'hABCD_ABCD) begin
            failures++; $display("FAIL half_store got be=%b wd=%h exp be=1100 wd=abcdabcd", be, wdo);
        end
        do_req(1'b1, 2'd2, 1'b0, 32'h31, 32'h0000_005A, rd, be, wdo, err);
        checks++;
        if (be !== 4'b0010 || wdo !== 32'h5A5A_5A5A) begin
            failures++; $display("FAIL byte_store got be=%b wd=%h exp be=0010 wd=5a5a5a5a", be, wdo);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, wdo, prev; logic [3:0] be; logic err;
        prev = mdr_exp;
        do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, rd, be, wdo, err);
        checks++;
`ifdef MEM_ALIGN_CHECK_EN
        if (err !== 1'b1 || rd !== prev) begin
            failures++; $display("FAIL misaligned_word got err=%b rd=%h exp err=1 rd=%h", err, rd, prev);
        end
`else
        if (err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL misaligned_word got err=%b rd=%h exp err=0 rd=deadbeef prev=%h", err, rd, prev);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int n_rdy, n_en, n_resp, k;
        logic [31:0] d;
        d = $urandom;
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = d;
        n_rdy = 0; n_en = 0; n_resp = 0;
        for (int i = 0; i < 30; i++) begin
            if (req_ready === 1'b1) n_rdy++;
            if (ram_en === 1'b1) n_en++;
            if (resp_valid === 1'b1) n_resp++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[32'h40 + i] = d[8*i +: 8];
        checks++;
        if (n_rdy != 10 || n_en != 10 || n_resp != 10) begin
            failures++; $display("FAIL back_to_back got rdy=%0d en=%0d resp=%0d exp 10 each", n_rdy, n_en, n_resp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        int n_resp;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h84;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, ram_en, ram_we, ram_be, ram_addr, resp_rdata, ram_wdata}
            !== {1'b1, 4'b0000, 4'b0000, {ADDR_W{1'b0}}, 64'd0}) begin
            failures++;
            $display("FAIL reset_mid_load got rdy=%b v=%b en=%b be=%b a=%h rd=%h exp rdy=1 rest 0",
                     req_ready, resp_valid, ram_en, ram_be, ram_addr, resp_rdata);
        end
        rst = 1'b0;
        mdr_exp = 32'd0;
        n_resp = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid === 1'b1 || resp_rdata !== 32'd0) n_resp++;
            @(negedge clk);
        end
        checks++;
        if (n_resp != 0) begin failures++; $display("FAIL late_resp_after_reset got=%0d exp=0", n_resp); end
    endtask

    task automatic test_random();
        logic [31:0] rd, wdo; logic [3:0] be; logic err;
        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 95)), $urandom, rd, be, wdo, err);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int w = 0; w < 256; w++)
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word(w) >> (8*b);
        test_reset();
        test_word_store_load();
        test_byte_loads();
        test_store_lanes();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multicycle control FSM.
- Accepts one load/store request at a time: word, halfword or byte size; address and write data come from the datapath.
- Drives a synchronous single-port word RAM with fixed read latency, using byte enables for sub-word stores.
- Returns a size-adjusted, sign- or zero-extended load result in a held MDR register, with a one-cycle completion pulse that the control FSM waits on.

Parameters:
- ADDR_W, 8, RAM word-address width; byte address bits [ADDR_W+1:2] select the word.
- READ_LAT, 2, cycles from the RAM issue cycle until ram_rdata is valid; legal range 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 word, 1 half, 2 byte, 3 reserved
- req_unsigned  in  1  zero-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  MDR: extended load data, held until the next load completes
- resp_err  out  1  misalignment flag, valid with resp_valid
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write
- ram_addr  out  ADDR_W  RAM word address
- ram_be  out  4  byte enables; bit i = bits 8i+7:8i
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  RAM read data

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_en=0, ram_we=0, ram_addr=0, ram_be=0, ram_wdata=0.
  - Reset mid-operation aborts the access; read data arriving later is ignored.
- Byte order: little-endian lanes; byte address offset 0 maps to bits 7:0.
- States: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance when req_valid && req_ready (cycle A); all req_* fields are latched.
  - Next state ISSUE.
- ISSUE (cycle A+1):
  - ram_en=1 for exactly this cycle; ram_addr = latched addr[ADDR_W+1:2].
  - Store: ram_we=1, next state RESP.
  - Load: ram_we=0, ram_be=4'b1111, counter loaded with READ_LAT-1, next state WAIT. If READ_LAT=1, go straight to CAPTURE.
- WAIT: counter decrements each cycle; at 0, go to CAPTURE.
- CAPTURE (cycle A+1+READ_LAT):
  - Sample ram_rdata.
  - Select lane by addr[1:0] (half: addr[1]).
  - Sign-extend unless req_unsigned; word loads pass through unchanged.
  - Result goes into the MDR; next state RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- Latency:
  - Load: resp_valid in cycle A+2+READ_LAT, which is A+4 at the default.
  - Store: resp_valid in cycle A+2.
- req_ready is 0 in all states except IDLE. The earliest back-to-back acceptance is the cycle after RESP.
- Store lanes:
  - Word: be=1111, wdata=req_wdata.
  - Half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - Byte: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
- Size 3 is treated as word.
- Stores leave the MDR unchanged.
- req_valid while not ready is ignored; no queueing.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A request is misaligned if it is a word with addr[1:0]!=0, a half with addr[0]!=0, or size 3.
  - A misaligned request skips ISSUE (no RAM access, ram_en stays 0) and goes A -> RESP.
  - RESP then has resp_valid=1 and resp_err=1; the MDR is unchanged.
- Undefined:
  - resp_err is tied 0.
  - Low address bits are ignored for alignment: word uses lanes 0-3; half uses the addr[1] lane pair.

Decomposition:
- Package mem_pkg holds:
  - Size encodings: SZ_WORD=0, SZ_HALF=1, SZ_BYTE=2, SZ_RSVD=3.
  - State encoding for IDLE..RESP.
  - Lane-select helper constants.
- One sub-module, mem_lane_extract: combinational lane select plus sign/zero extension from (rdata, addr[1:0], size, unsigned) to a 32-bit result.
- The store lane/byte-enable generation stays inline.

Test Plan:
- Word store then load: store addr 0x10, wdata 0xDEADBEEF; ram_be=1111 at ram_addr 4, resp_valid at A+2. Load 0x10 -> resp_rdata=0xDEADBEEF at A+4.
- Signed/unsigned byte load: RAM word 0x80FF7F01 at addr 0x20. Byte load of 0x23 signed -> 0xFFFFFF80. Byte 0x22 unsigned -> 0x000000FF. Byte 0x20 signed -> 0x00000001.
- Half store lanes: half store addr 0x32, wdata 0x0000ABCD -> ram_be=1100, ram_wdata=0xABCDABCD. Byte store addr 0x31, data 0x5A -> ram_be=0010.
- Handshake: req_valid held high continuously -> accepts only in IDLE, one per transaction, with req_ready low from A+1 through RESP. READ_LAT=1 build -> load resp at A+3.
- Reset mid-load: rst asserted in WAIT -> next cycle IDLE, all outputs at reset values. No resp_valid follows; the late ram_rdata is ignored.
- MEM_ALIGN_CHECK_EN: word load at 0x12 -> ram_en never asserted, resp_valid=1 with resp_err=1 at A+1, MDR unchanged. Without the macro: word at 0x12 reads word 4, resp_err=0.
